// File: rtl/ex2_operand_loader.sv
// ex2_operand_loader: assembles the two WIDTH-bit ex2 operands P and Q from an
// MSB-first serial stream (all P bits, then all Q bits) and presents them as a
// registered, stable pair with a valid/ack handshake. P and Q update only when
// a complete new pair has been received; every output is a flop.
module ex2_operand_loader #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdi,
    input  logic             sdi_en,
    input  logic             op_ack,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             op_valid,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_P  = 2'd1,
        LOAD_Q  = 2'd2,
        PRESENT = 2'd3
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   p_sh_q,     p_sh_d;
    logic [WIDTH-1:0]   q_sh_q,     q_sh_d;
    logic [WIDTH-1:0]   p_q,        p_d;
    logic [WIDTH-1:0]   q_q,        q_d;
    logic               op_valid_q, op_valid_d;
    logic               busy_q,     busy_d;
    logic               err_q,      err_d;

    logic               last_bit;

    // The accepted bit is the WIDTH-th of the current operand.
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state, shift and handshake decode.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_sh_d     = p_sh_q;
        q_sh_d     = q_sh_q;
        p_d        = p_q;
        q_d        = q_q;
        op_valid_d = op_valid_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_P;
                    cnt_d   = '0;
                    p_sh_d  = '0;
                    q_sh_d  = '0;
                end
            end

            LOAD_P: begin
                // A start here is refused; the load carries on untouched.
                if (start) begin
                    err_d = 1'b1;
                end
                if (sdi_en) begin
                    p_sh_d = {p_sh_q[WIDTH-2:0], sdi};
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = LOAD_Q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            LOAD_Q: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (sdi_en) begin
                    q_sh_d = {q_sh_q[WIDTH-2:0], sdi};
                    if (last_bit) begin
                        // Publish the whole pair at once, final Q bit included.
                        cnt_d      = '0;
                        p_d        = p_sh_q;
                        q_d        = {q_sh_q[WIDTH-2:0], sdi};
                        op_valid_d = 1'b1;
                        state_d    = PRESENT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            PRESENT: begin
                if (op_ack) begin
                    op_valid_d = 1'b0;
                    if (start) begin
                        // Back-to-back: ack honoured, next load begins directly.
                        state_d = LOAD_P;
                        cnt_d   = '0;
                        p_sh_d  = '0;
                        q_sh_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy tracks the state being entered so the flop matches the state register.
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_sh_q     <= '0;
            q_sh_q     <= '0;
            p_q        <= '0;
            q_q        <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_sh_q     <= p_sh_d;
            q_sh_q     <= q_sh_d;
            p_q        <= p_d;
            q_q        <= q_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign P        = p_q;
    assign Q        = q_q;
    assign op_valid = op_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ex2_operand_loader.sv
// Directed bench for ex2_operand_loader: one task per scenario, each with its
// own inline comparisons against hand-computed values.
module tb_ex2_operand_loader;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sdi;
    logic         sdi_en;
    logic         op_ack;
    logic [W-1:0] P;
    logic [W-1:0] Q;
    logic         op_valid;
    logic         busy;
    logic         err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex2_operand_loader #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sdi      (sdi),
        .sdi_en   (sdi_en),
        .op_ack   (op_ack),
        .P        (P),
        .Q        (Q),
        .op_valid (op_valid),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled at the next edge
    // and outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bit(input logic b);
        sdi    = b;
        sdi_en = 1'b1;
        step();
        sdi_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
    endtask

    // Ten back-to-back bits, P MSB first then Q MSB first.
    task automatic load_pair(input logic [W-1:0] p, input logic [W-1:0] q);
        for (int i = W - 1; i >= 0; i--) send_bit(p[i]);
        for (int i = W - 1; i >= 0; i--) send_bit(q[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({op_valid, busy, err, P, Q} !== {3'b000, 5'd0, 5'd0}) begin
            $display("FAIL reset_state: got valid=%b busy=%b err=%b P=%0d Q=%0d, expected all 0",
                     op_valid, busy, err, P, Q);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        pulse_start();
        total_cnt++;
        if ({busy, op_valid} !== 2'b10) begin
            $display("FAIL basic_start: got busy=%b valid=%b, expected busy=1 valid=0", busy, op_valid);
        end else pass_cnt++;
        // 1,0,1,1,0 -> 22 ; 0,1,1,0,1 -> 13
        for (int i = W - 1; i >= 0; i--) send_bit(5'd22 >> i);
        for (int i = W - 1; i > 0; i--) send_bit(5'd13 >> i);
        total_cnt++;
        if (op_valid !== 1'b0) begin
            $display("FAIL basic_before_last: got valid=%b, expected 0", op_valid);
        end else pass_cnt++;
        send_bit(1'b1);
        total_cnt++;
        if ({op_valid, busy, P, Q} !== {2'b11, 5'd22, 5'd13}) begin
            $display("FAIL basic_pair: got valid=%b busy=%b P=%0d Q=%0d, expected valid=1 busy=1 P=22 Q=13",
                     op_valid, busy, P, Q);
        end else pass_cnt++;
        pulse_ack();
        total_cnt++;
        if ({op_valid, busy, P, Q} !== {2'b00, 5'd22, 5'd13}) begin
            $display("FAIL basic_ack: got valid=%b busy=%b P=%0d Q=%0d, expected valid=0 busy=0 P=22 Q=13",
                     op_valid, busy, P, Q);
        end else pass_cnt++;
        // op_ack outside PRESENT has no effect.
        pulse_ack();
        total_cnt++;
        if ({op_valid, busy, err, P, Q} !== {3'b000, 5'd22, 5'd13}) begin
            $display("FAIL idle_ack_ignored: got valid=%b busy=%b err=%b P=%0d Q=%0d, expected 0/0/0 P=22 Q=13",
                     op_valid, busy, err, P, Q);
        end else pass_cnt++;
    endtask

    task automatic test_hold();
        pulse_start();
        load_pair(5'd10, 5'd21);
        total_cnt++;
        if ({op_valid, P, Q} !== {1'b1, 5'd10, 5'd21}) begin
            $display("FAIL hold_pair: got valid=%b P=%0d Q=%0d, expected valid=1 P=10 Q=21", op_valid, P, Q);
        end else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            sdi    = i[0];
            sdi_en = i[1];
            step();
            total_cnt++;
            if ({op_valid, busy, err, P, Q} !== {3'b110, 5'd10, 5'd21}) begin
                $display("FAIL hold_cycle%0d: got valid=%b busy=%b err=%b P=%0d Q=%0d, expected 1/1/0 P=10 Q=21",
                         i, op_valid, busy, err, P, Q);
            end else pass_cnt++;
        end
        sdi_en = 1'b0;
        // start without ack in PRESENT is refused.
        pulse_start();
        total_cnt++;
        if ({err, op_valid, P, Q} !== {2'b11, 5'd10, 5'd21}) begin
            $display("FAIL present_start_err: got err=%b valid=%b P=%0d Q=%0d, expected err=1 valid=1 P=10 Q=21",
                     err, op_valid, P, Q);
        end else pass_cnt++;
        pulse_ack();
        total_cnt++;
        if ({op_valid, busy, err} !== 3'b000) begin
            $display("FAIL hold_ack: got valid=%b busy=%b err=%b, expected 000", op_valid, busy, err);
        end else pass_cnt++;
    endtask

    task automatic test_start_during_load();
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_start();
        total_cnt++;
        if ({err, busy} !== 2'b11) begin
            $display("FAIL load_start_err: got err=%b busy=%b, expected err=1 busy=1", err, busy);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (err !== 1'b0) begin
            $display("FAIL load_err_one_cycle: got err=%b, expected 0", err);
        end else pass_cnt++;
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = W - 1; i >= 0; i--) send_bit(5'd13 >> i);
        total_cnt++;
        if ({op_valid, P, Q} !== {1'b1, 5'd22, 5'd13}) begin
            $display("FAIL load_start_pair: got valid=%b P=%0d Q=%0d, expected valid=1 P=22 Q=13", op_valid, P, Q);
        end else pass_cnt++;
    endtask

    // Entered in PRESENT holding P=22, Q=13.
    task automatic test_back_to_back();
        start  = 1'b1;
        op_ack = 1'b1;
        step();
        start  = 1'b0;
        op_ack = 1'b0;
        total_cnt++;
        if ({op_valid, busy, err, P, Q} !== {3'b010, 5'd22, 5'd13}) begin
            $display("FAIL b2b_ack: got valid=%b busy=%b err=%b P=%0d Q=%0d, expected 0/1/0 P=22 Q=13",
                     op_valid, busy, err, P, Q);
        end else pass_cnt++;
        load_pair(5'd5, 5'd9);
        total_cnt++;
        if ({op_valid, busy, P, Q} !== {2'b11, 5'd5, 5'd9}) begin
            $display("FAIL b2b_pair: got valid=%b busy=%b P=%0d Q=%0d, expected valid=1 busy=1 P=5 Q=9",
                     op_valid, busy, P, Q);
        end else pass_cnt++;
        pulse_ack();
    endtask

    // Entered in IDLE holding P=5, Q=9.
    task automatic test_gapped();
        logic [2*W-1:0] bits;
        bits = {5'd22, 5'd13};
        pulse_start();
        for (int i = 2 * W - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i != 0) begin
                idle((i % 3) + 1);
                total_cnt++;
                if ({op_valid, busy, P, Q} !== {2'b01, 5'd5, 5'd9}) begin
                    $display("FAIL gap_hold_bit%0d: got valid=%b busy=%b P=%0d Q=%0d, expected valid=0 busy=1 P=5 Q=9",
                             i, op_valid, busy, P, Q);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if ({op_valid, P, Q} !== {1'b1, 5'd22, 5'd13}) begin
            $display("FAIL gap_pair: got valid=%b P=%0d Q=%0d, expected valid=1 P=22 Q=13", op_valid, P, Q);
        end else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = W - 1; i >= 0; i--) send_bit(5'd22 >> i);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({op_valid, busy, err, P, Q} !== {3'b000, 5'd0, 5'd0}) begin
            $display("FAIL midreset_state: got valid=%b busy=%b err=%b P=%0d Q=%0d, expected all 0",
                     op_valid, busy, err, P, Q);
        end else pass_cnt++;
        // sdi_en in IDLE must not start or disturb anything.
        send_bit(1'b1);
        total_cnt++;
        if ({busy, op_valid} !== 2'b00) begin
            $display("FAIL idle_sdi_ignored: got busy=%b valid=%b, expected 00", busy, op_valid);
        end else pass_cnt++;
        pulse_start();
        load_pair(5'd31, 5'd0);
        total_cnt++;
        if ({op_valid, P, Q} !== {1'b1, 5'd31, 5'd0}) begin
            $display("FAIL midreset_reload: got valid=%b P=%0d Q=%0d, expected valid=1 P=31 Q=0", op_valid, P, Q);
        end else pass_cnt++;
        // Reset while presenting drops the pair.
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({op_valid, busy, P, Q} !== {2'b00, 5'd0, 5'd0}) begin
            $display("FAIL present_reset: got valid=%b busy=%b P=%0d Q=%0d, expected all 0", op_valid, busy, P, Q);
        end else pass_cnt++;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sdi    = 1'b0;
        sdi_en = 1'b0;
        op_ack = 1'b0;
        idle(2);
        test_reset();
        test_basic();
        test_hold();
        test_start_during_load();
        test_back_to_back();
        test_gapped();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex2_operand_loader.md
Name: ex2_operand_loader

Overview:
- Upstream stage for the ex2 arithmetic/logic datapath.
- Assembles the two 5-bit operands P and Q from a serial bit stream.
- Presents both operands together, registered and stable, with a valid/ack handshake, so that the downstream combinational block always sees a consistent operand pair.
- Operand outputs change only when a complete new pair has been received.

Parameters:
- WIDTH, 5: bit width of each operand (P and Q). Minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin loading a new operand pair.
- sdi  input  1  serial data bit, MSB first: P bits first, then Q bits.
- sdi_en  input  1  qualifies sdi; a bit is accepted only on cycles with sdi_en=1 in a LOAD state.
- op_ack  input  1  downstream has consumed the presented pair.
- P  output  WIDTH  registered operand P to ex2.
- Q  output  WIDTH  registered operand Q to ex2.
- op_valid  output  1  P/Q hold a freshly loaded pair that is not yet acknowledged.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse when start is ignored.

Behaviour:
- Reset: checked synchronously on the clock edge; overrides all other inputs.
  - State goes to IDLE.
  - P, Q, shadow registers and bit counter all clear to 0.
  - op_valid, busy and err go to 0.
  - A reset during LOAD_P, LOAD_Q or PRESENT discards the partial or presented pair. P and Q read 0 on the following cycle.
- States: IDLE, LOAD_P, LOAD_Q, PRESENT.
- IDLE:
  - start=1 moves to LOAD_P and clears the bit counter and both shadow registers.
  - sdi_en is ignored.
- LOAD_P:
  - Each cycle with sdi_en=1 shifts sdi into the P shadow register, new bit entering at the LSB: p_sh <= {p_sh[WIDTH-2:0], sdi}. The counter increments.
  - When the WIDTH-th bit is accepted, the counter clears and the state moves to LOAD_Q.
  - Cycles with sdi_en=0 hold all state; gaps of any length are allowed.
- LOAD_Q:
  - Same shifting rule, applied to the Q shadow register.
  - On the cycle the WIDTH-th Q bit is accepted: P <= p_sh, Q <= q_sh with that bit included, op_valid <= 1, state moves to PRESENT.
  - Latency: op_valid and the new P/Q are visible one cycle after the edge that samples the final Q bit.
- PRESENT:
  - op_valid=1. P and Q are held.
  - sdi_en is ignored.
  - op_ack=1 moves to IDLE; op_valid=0 from the next cycle.
  - P and Q keep their values after ack until the next pair completes or a reset occurs.
- start ignored:
  - In LOAD_P, LOAD_Q, or in PRESENT without op_ack: start is ignored, and err=1 for exactly the next cycle.
  - The load in progress is unaffected.
- Simultaneous start and op_ack in PRESENT:
  - The ack is honoured and the state goes directly to LOAD_P (back-to-back load).
  - Shadow registers and counter are cleared; err stays 0.
  - op_valid drops the next cycle; P and Q keep the old pair until the new one completes.
- op_ack outside PRESENT: ignored.
- busy is a registered decode of state: 1 in LOAD_P, LOAD_Q and PRESENT.
- No combinational path from any input to any output. All outputs are registers.

Test Plan:
- Basic load: start, then 10 consecutive sdi_en=1 bits 1,0,1,1,0 then 0,1,1,0,1 -> the cycle after the last bit, P=22, Q=13, op_valid=1, busy=1. op_ack for one cycle -> op_valid=0, busy=0, P=22, Q=13 held.
- Gapped stream: same bits with sdi_en=0 on 1-3 idle cycles between bits -> identical final result. P/Q keep their previous values and op_valid=0 throughout loading.
- Hold without ack: after the pair completes, keep op_ack=0 for 20 cycles while toggling sdi/sdi_en -> op_valid stays 1; P and Q unchanged.
- Start during load: start asserted after 3 P bits -> err=1 for one cycle only. The load continues, and the final P/Q match the full 10-bit stream.
- Reset mid-load: rst after 7 bits -> next cycle state is IDLE, P=0, Q=0, op_valid=0, busy=0. A subsequent clean 10-bit load of P=31, Q=0 completes correctly.
- Back-to-back: in PRESENT with P=22/Q=13, assert start and op_ack together -> op_valid=0, busy=1, err=0, P=22/Q=13 held. A following load of P=5, Q=9 yields P=5, Q=9, op_valid=1.
